// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its control unit: opcode encoding,
// handshake FSM states and the default datapath width.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_MUL  = 3'b010,
    ALU_DIV  = 3'b011,
    OP_LOAD  = 3'b100,
    OP_STORE = 3'b101,
    ALU_AND  = 3'b110,
    ALU_XOR  = 3'b111
  } alu_opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one step per cycle.
// The divider path exists only when ALU_DIV_EN is defined.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
`ifdef ALU_DIV_EN
  input  logic             i_isDiv,
`endif
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_nextHi,
  output logic [WIDTH-1:0] o_nextLo
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_count;
  logic             r_active;
`ifdef ALU_DIV_EN
  logic             r_isDiv;
`endif

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_mulHi;
  logic [WIDTH-1:0] w_mulLo;

  // Multiply step: conditionally add the multiplicand into the high half,
  // then shift {carry, hi, lo} right by one.
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_mulHi = w_sum[WIDTH:1];
  assign w_mulLo = {w_sum[0], r_lo[WIDTH-1:1]};

`ifdef ALU_DIV_EN
  logic [WIDTH:0]   w_shRem;
  logic [WIDTH+1:0] w_diff;
  logic             w_borrow;
  logic [WIDTH-1:0] w_divHi;
  logic [WIDTH-1:0] w_divLo;

  // Restoring step: shift the next dividend bit into the remainder and keep
  // the trial subtraction only when it does not go negative.
  assign w_shRem  = {r_hi, r_lo[WIDTH-1]};
  assign w_diff   = {1'b0, w_shRem} - {2'b00, r_b};
  assign w_borrow = w_diff[WIDTH+1];
  assign w_divHi  = w_borrow ? w_shRem[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_divLo  = {r_lo[WIDTH-2:0], ~w_borrow};

  assign o_nextHi = r_isDiv ? w_divHi : w_mulHi;
  assign o_nextLo = r_isDiv ? w_divLo : w_mulLo;
`else
  assign o_nextHi = w_mulHi;
  assign o_nextLo = w_mulLo;
`endif

  assign o_last = r_active && (r_count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_count  <= '0;
      r_active <= 1'b0;
`ifdef ALU_DIV_EN
      r_isDiv  <= 1'b0;
`endif
    end else if (i_load) begin
      r_hi     <= '0;
      r_lo     <= i_a;
      r_b      <= i_b;
      r_count  <= '0;
      r_active <= 1'b1;
`ifdef ALU_DIV_EN
      r_isDiv  <= i_isDiv;
`endif
    end else if (r_active) begin
      r_hi    <= o_nextHi;
      r_lo    <= o_nextLo;
      r_count <= r_count + 1'b1;
      if (o_last) begin
        r_active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_unit.sv
// Multi-cycle integer ALU with level-start / pulse-done handshake.
// Optional divider enabled by defining ALU_DIV_EN; otherwise opcode 011 is illegal.
module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_start,
  input  logic [2:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  output logic [WIDTH:0]   alu_result_low,
  output logic [WIDTH:0]   alu_result_high,
  output logic             alu_done,
  output logic             alu_busy,
  output logic             alu_error
);

  alu_state_e       r_state;
  logic [WIDTH:0]   r_low;
  logic [WIDTH:0]   r_high;
  logic             r_done;
  logic             r_busy;
  logic             r_error;

  alu_opcode_e      w_op;
  logic             w_accept;
  logic             w_load;
  logic             w_last;
  logic [WIDTH-1:0] w_nextHi;
  logic [WIDTH-1:0] w_nextLo;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;

  assign w_op     = alu_opcode_e'(alu_opcode);
  assign w_accept = (r_state == IDLE) && alu_start;
  assign w_add    = {1'b0, alu_a} + {1'b0, alu_b};
  assign w_sub    = {1'b0, alu_a} - {1'b0, alu_b};

`ifdef ALU_DIV_EN
  logic w_isDiv;
  assign w_isDiv = (w_op == ALU_DIV);
  // Divide-by-zero finishes in the accept cycle, so only a nonzero divisor starts the iterator.
  assign w_load  = w_accept && ((w_op == ALU_MUL) || (w_isDiv && (alu_b != '0)));
`else
  assign w_load  = w_accept && (w_op == ALU_MUL);
`endif

  alu_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
`ifdef ALU_DIV_EN
    .i_isDiv (w_isDiv),
`endif
    .i_a     (alu_a),
    .i_b     (alu_b),
    .o_last  (w_last),
    .o_nextHi(w_nextHi),
    .o_nextLo(w_nextLo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_low   <= '0;
      r_high  <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (alu_start) begin
            r_busy <= 1'b1;
            case (w_op)
              ALU_ADD: begin
                r_low   <= w_add;
                r_high  <= '0;
                r_error <= 1'b0;
                r_done  <= 1'b1;
                r_state <= HOLD;
              end
              ALU_SUB: begin
                r_low   <= w_sub;
                r_high  <= '0;
                r_error <= 1'b0;
                r_done  <= 1'b1;
                r_state <= HOLD;
              end
              ALU_AND: begin
                r_low   <= {1'b0, alu_a & alu_b};
                r_high  <= '0;
                r_error <= 1'b0;
                r_done  <= 1'b1;
                r_state <= HOLD;
              end
              ALU_XOR: begin
                r_low   <= {1'b0, alu_a ^ alu_b};
                r_high  <= '0;
                r_error <= 1'b0;
                r_done  <= 1'b1;
                r_state <= HOLD;
              end
              ALU_MUL: begin
                r_state <= BUSY;
              end
`ifdef ALU_DIV_EN
              ALU_DIV: begin
                if (alu_b == '0) begin
                  r_low   <= {1'b0, {WIDTH{1'b1}}};
                  r_high  <= {1'b0, alu_a};
                  r_error <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= HOLD;
                end else begin
                  r_state <= BUSY;
                end
              end
`endif
              default: begin
                r_low   <= '0;
                r_high  <= '0;
                r_error <= 1'b1;
                r_done  <= 1'b1;
                r_state <= HOLD;
              end
            endcase
          end
        end
        BUSY: begin
          if (w_last) begin
            r_low   <= {1'b0, w_nextLo};
            r_high  <= {1'b0, w_nextHi};
            r_error <= 1'b0;
            r_done  <= 1'b1;
            r_state <= HOLD;
          end
        end
        // Wait for the requester to drop its level start so it cannot retrigger.
        HOLD: begin
          if (!alu_start) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign alu_result_low  = r_low;
  assign alu_result_high = r_high;
  assign alu_done        = r_done;
  assign alu_busy        = r_busy;
  assign alu_error       = r_error;

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
Multi-cycle integer ALU directly downstream of control_unit's EXECUTE stage. Accepts an opcode and two 16-bit operands under a level start / pulse done handshake. Returns a 17-bit low and a 17-bit high result.
- Add/sub/logic complete in 1 cycle.
- Unsigned multiply and divide iterate over WIDTH cycles.

Parameters:
WIDTH, 16, operand width; results are WIDTH+1 bits.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
alu_start  input  1  level request; held high by the requester until it samples alu_done
alu_opcode  input  3  operation select, sampled only on accept
alu_a  input  WIDTH  operand A, sampled only on accept
alu_b  input  WIDTH  operand B, sampled only on accept
alu_result_low  output  WIDTH+1  primary result
alu_result_high  output  WIDTH+1  secondary result (MUL high half / DIV remainder)
alu_done  output  1  one-cycle completion pulse
alu_busy  output  1  high from accept until return to IDLE
alu_error  output  1  illegal opcode or divide-by-zero on the last operation; valid with alu_done

Behaviour:
- Reset (synchronous): state=IDLE. All outputs 0, including both results. Any in-flight operation is discarded; no done pulse for it.

States:
- IDLE: alu_start=1 accepts the request. Latch opcode and operands, set alu_busy=1.
  - Single-cycle ops: write results, alu_done=1, go to HOLD.
  - MUL/DIV: load iteration registers, go to BUSY.
- BUSY: one iteration per cycle, WIDTH iterations (count 0..WIDTH-1). On the final iteration, write results, alu_done=1, go to HOLD.
- HOLD:
  - alu_done returns to 0 on the first cycle in HOLD.
  - Stay while alu_start=1. This blocks re-triggering from the requester's still-high start.
  - alu_start=0 goes to IDLE with alu_busy=0.
  - Results and alu_error are held until the next accept.

Latency (accept edge to alu_done high): 1 cycle for ADD/SUB/AND/XOR/illegal; WIDTH+1 (17) for MUL/DIV.

Opcodes and results:
- 000 ADD: low={carry, a+b}, high=0.
- 001 SUB: low={borrow, a-b}, high=0; borrow=1 when a<b.
- 010 MUL: unsigned shift-add; low={0, prod[15:0]}, high={0, prod[31:16]}.
- 011 DIV: unsigned restoring division; low={0, quotient}, high={0, remainder}.
  - b=0: 1-cycle completion, quotient=all ones, remainder=a, alu_error=1.
- 110 AND: low={0, a&b}, high=0.
- 111 XOR: low={0, a^b}, high=0.
- 100, 101 (load/store opcodes, not ALU ops): 1-cycle completion, both results 0, alu_error=1.

Boundary conditions:
- alu_start dropping during BUSY: ignored; the operation completes and alu_done still pulses.
- Operand or opcode changes after accept: no effect.
- alu_start high in IDLE on the cycle after HOLD exits: a new accept.
- Reset asserted in the same cycle as completion: reset wins, alu_done=0.

Optional Feature:
Macro ALU_DIV_EN.
- Defined: opcode 011 implements division as above.
- Undefined: no divider hardware; 011 behaves as an illegal opcode (1 cycle, results 0, alu_error=1).

Decomposition:
- Shared package alu_pkg holds:
  - opcode enum (ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV, ALU_AND, ALU_XOR, OP_LOAD, OP_STORE);
  - ALU state enum (IDLE, BUSY, HOLD);
  - WIDTH default constant.
- control_unit uses the same package for opcode decode.
- One natural sub-module: alu_muldiv_iter. It holds the iterative shift-add/restoring datapath, iteration counter and last-iteration flag. The top level keeps the handshake FSM and the single-cycle ops.

Test Plan:
- ADD a=0xFFFF b=0x0001, start held until done -> done 1 cycle after accept; low=0x10000, high=0, error=0; done pulses exactly once while start stays high for 2 more cycles.
- SUB a=0x0003 b=0x0005 -> low=0x1FFFE (borrow=1), 1-cycle latency.
- MUL a=0x1234 b=0x5678 -> done 17 cycles after accept; low=0x00060, high=0x00626; busy high throughout.
- DIV a=100 b=7 -> low=14, high=2 after 17 cycles. DIV a=0x00AB b=0 -> 1 cycle; low=0x0FFFF, high=0x000AB, error=1. Without ALU_DIV_EN: both divides give results 0, error=1.
- Opcode 100 -> 1 cycle; both results 0, error=1.
- Reset asserted mid-MUL (cycle 8) -> next edge: IDLE, all outputs 0, no done. A following ADD 2+3 returns low=5.
